// File: rtl/vga_text_render.sv
// Character-cell text renderer sitting directly behind the VGA sync generator.
// Three-stage pipeline: text RAM address -> glyph row fetch -> pixel/colour select.
// Optional feature macro: CURSOR_BLINK_EN (frame-counted blinking cursor).
module vga_text_render #(
    parameter int unsigned COLS         = 160,
    parameter int unsigned ROWS         = 64,
    parameter int unsigned CHAR_W       = 8,
    parameter int unsigned CHAR_H       = 16,
    parameter int unsigned BLINK_FRAMES = 32
) (
    input  logic        CLK,
    input  logic        RESETn,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        hdisp_in,
    input  logic        vdisp_in,
    input  logic [10:0] hpix,
    input  logic [10:0] vpix,
    output logic [13:0] text_addr,
    input  logic [15:0] text_data,
    output logic [11:0] font_addr,
    input  logic [7:0]  font_data,
    input  logic [7:0]  cursor_col,
    input  logic [5:0]  cursor_row,
    input  logic        cursor_on,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic [3:0]  red,
    output logic [3:0]  green,
    output logic [3:0]  blue
);

    localparam int unsigned PIX_W  = 11;
    localparam int unsigned ADDR_W = 14;
    localparam int unsigned X_W    = $clog2(CHAR_W);
    localparam int unsigned Y_W    = $clog2(CHAR_H);
    localparam int unsigned COL_W  = PIX_W - X_W;
    localparam int unsigned ROW_W  = PIX_W - Y_W;

    // ---------------- S0: cell lookup (combinational) ----------------
    logic              w_active;
    logic [COL_W-1:0]  w_col;
    logic [ROW_W-1:0]  w_row;
    logic [ADDR_W-1:0] w_cell_addr;
    logic              w_cursor_hit;

    assign w_active     = hdisp_in & vdisp_in;
    assign w_col        = hpix[PIX_W-1:X_W];
    assign w_row        = vpix[PIX_W-1:Y_W];
    // Constant multiplier reduces to shift-add; max address 10239 fits in 14 bits.
    assign w_cell_addr  = ADDR_W'(w_row) * ADDR_W'(COLS) + ADDR_W'(w_col);
    assign text_addr    = (w_active && RESETn) ? w_cell_addr : '0;
    assign w_cursor_hit = (w_col == COL_W'(cursor_col)) && (w_row == ROW_W'(cursor_row));

    // ---------------- S1 registers ----------------
    logic [7:0]     r1_char;
    logic [2:0]     r1_fg;
    logic [2:0]     r1_bg;
    logic [X_W-1:0] r1_x;
    logic [Y_W-1:0] r1_y;
    logic           r1_active;
    logic           r1_hit;
    logic           r1_hs;
    logic           r1_vs;

    // Capture the text word together with the in-cell position and syncs.
    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            r1_char   <= '0;
            r1_fg     <= '0;
            r1_bg     <= '0;
            r1_x      <= '0;
            r1_y      <= '0;
            r1_active <= 1'b0;
            r1_hit    <= 1'b0;
            r1_hs     <= 1'b0;
            r1_vs     <= 1'b0;
        end else begin
            r1_char   <= text_data[7:0];
            r1_fg     <= text_data[10:8];
            r1_bg     <= text_data[13:11];
            r1_x      <= hpix[X_W-1:0];
            r1_y      <= vpix[Y_W-1:0];
            r1_active <= w_active;
            r1_hit    <= w_cursor_hit;
            r1_hs     <= hsync_in;
            r1_vs     <= vsync_in;
        end
    end

    assign font_addr = 12'({r1_char, r1_y});

    // ---------------- S2 registers ----------------
    logic [7:0]     r2_font;
    logic [2:0]     r2_fg;
    logic [2:0]     r2_bg;
    logic [X_W-1:0] r2_x;
    logic           r2_active;
    logic           r2_hit;
    logic           r2_hs;
    logic           r2_vs;

    // Capture the glyph row alongside the delayed cell attributes.
    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            r2_font   <= '0;
            r2_fg     <= '0;
            r2_bg     <= '0;
            r2_x      <= '0;
            r2_active <= 1'b0;
            r2_hit    <= 1'b0;
            r2_hs     <= 1'b0;
            r2_vs     <= 1'b0;
        end else begin
            r2_font   <= font_data;
            r2_fg     <= r1_fg;
            r2_bg     <= r1_bg;
            r2_x      <= r1_x;
            r2_active <= r1_active;
            r2_hit    <= r1_hit;
            r2_hs     <= r1_hs;
            r2_vs     <= r1_vs;
        end
    end

    // ---------------- cursor blink phase ----------------
    logic w_phase_vis;
    logic w_unused_cfg;

    assign w_unused_cfg = ^{text_data[15:14], (ROWS == 0)};

`ifdef CURSOR_BLINK_EN
    localparam int unsigned BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic               r_vs_d;
    logic [BLINK_W-1:0] r_blink_cnt;
    logic               r_phase_hidden;
    logic               w_frame_evt;

    assign w_frame_evt = r_vs_d & ~vsync_in;
    assign w_phase_vis = ~r_phase_hidden;

    // Count vsync falling edges; flip the cursor phase each time the count wraps.
    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            r_vs_d         <= 1'b0;
            r_blink_cnt    <= '0;
            r_phase_hidden <= 1'b0;
        end else begin
            r_vs_d <= vsync_in;
            if (w_frame_evt) begin
                if (r_blink_cnt == BLINK_W'(BLINK_FRAMES - 1)) begin
                    r_blink_cnt    <= '0;
                    r_phase_hidden <= ~r_phase_hidden;
                end else begin
                    r_blink_cnt <= r_blink_cnt + BLINK_W'(1);
                end
            end
        end
    end
`else
    logic w_unused_blink;

    assign w_unused_blink = (BLINK_FRAMES == 0);
    assign w_phase_vis    = 1'b1;
`endif

    // ---------------- output stage ----------------
    logic [X_W-1:0] w_bit_idx;
    logic           w_pix;
    logic           w_invert;
    logic [2:0]     w_sel;

    // Swapping fg/bg on a cursor cell is the same as inverting the glyph bit.
    assign w_bit_idx = X_W'(CHAR_W - 1) - r2_x;
    assign w_pix     = r2_font[w_bit_idx];
    assign w_invert  = r2_hit & cursor_on & w_phase_vis;
    assign w_sel     = (w_pix ^ w_invert) ? r2_fg : r2_bg;

    // Register colour and re-aligned syncs; blank outside the active area.
    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            hsync_out <= 1'b0;
            vsync_out <= 1'b0;
            red       <= '0;
            green     <= '0;
            blue      <= '0;
        end else begin
            hsync_out <= r2_hs;
            vsync_out <= r2_vs;
            red       <= r2_active ? {4{w_sel[2]}} : 4'h0;
            green     <= r2_active ? {4{w_sel[1]}} : 4'h0;
            blue      <= r2_active ? {4{w_sel[0]}} : 4'h0;
        end
    end

endmodule

// File: tb/tb_vga_text_render.sv
// Bench for vga_text_render: behavioural text RAM / font ROM, a 3-deep
// expected-output queue for every cycle, plus directed constant checks.
module tb_vga_text_render;

    localparam int unsigned BF = 2;
`ifdef CURSOR_BLINK_EN
    localparam bit BLINK_EN = 1'b1;
`else
    localparam bit BLINK_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        hsync_in = 1'b1;
    logic        vsync_in = 1'b1;
    logic        hdisp_in = 1'b0;
    logic        vdisp_in = 1'b0;
    logic [10:0] hpix = '0;
    logic [10:0] vpix = '0;
    logic [13:0] text_addr;
    logic [15:0] text_data;
    logic [11:0] font_addr;
    logic [7:0]  font_data;
    logic [7:0]  cursor_col = 8'd2;
    logic [5:0]  cursor_row = 6'd2;
    logic        cursor_on = 1'b0;
    logic        hsync_out;
    logic        vsync_out;
    logic [3:0]  red;
    logic [3:0]  green;
    logic [3:0]  blue;

    logic [15:0] tmem [0:16383];
    logic [7:0]  fmem [0:4095];

    logic [13:0] sb_q [$];
    int          checks = 0;
    int          failures = 0;
    int          blink_cnt = 0;
    bit          phase_vis = 1'b1;
    bit          prev_vs = 1'b0;
    logic [13:0] m_got;
    logic [13:0] m_exp;
    logic [13:0] got;

    vga_text_render #(.BLINK_FRAMES(BF)) dut (
        .CLK(clk), .RESETn(rst_n),
        .hsync_in(hsync_in), .vsync_in(vsync_in),
        .hdisp_in(hdisp_in), .vdisp_in(vdisp_in),
        .hpix(hpix), .vpix(vpix),
        .text_addr(text_addr), .text_data(text_data),
        .font_addr(font_addr), .font_data(font_data),
        .cursor_col(cursor_col), .cursor_row(cursor_row), .cursor_on(cursor_on),
        .hsync_out(hsync_out), .vsync_out(vsync_out),
        .red(red), .green(green), .blue(blue)
    );

    always #5 clk = ~clk;

    assign text_data = tmem[text_addr];
    assign font_data = fmem[font_addr];

    // Reference pixel: {hsync, vsync, R4, G4, B4} for one input cycle.
    function automatic logic [13:0] model_pix(input logic hs, input logic vs,
                                              input logic hd, input logic vd,
                                              input logic [10:0] hp, input logic [10:0] vp);
        logic [13:0] a;
        logic [15:0] td;
        logic [7:0]  fd;
        logic [2:0]  fg, bg, sel;
        logic        b;
        int          col, row;
        if (!(hd && vd)) return {hs, vs, 12'h000};
        col = int'(hp) / 8;
        row = int'(vp) / 16;
        a   = 14'(row * 160 + col);
        td  = tmem[a];
        fd  = fmem[{td[7:0], vp[3:0]}];
        b   = fd[7 - int'(hp[2:0])];
        fg  = td[10:8];
        bg  = td[13:11];
        if (col == int'(cursor_col) && row == int'(cursor_row) && cursor_on && phase_vis) begin
            sel = fg; fg = bg; bg = sel;
        end
        sel = b ? fg : bg;
        return {hs, vs, {4{sel[2]}}, {4{sel[1]}}, {4{sel[0]}}};
    endfunction

    // Drive one cycle of inputs on the falling edge and queue its expected output.
    task automatic step(input logic rst, input logic hs, input logic vs,
                        input logic hd, input logic vd, input int hp, input int vp);
        @(negedge clk);
        rst_n    = rst;
        hsync_in = hs;
        vsync_in = vs;
        hdisp_in = hd;
        vdisp_in = vd;
        hpix     = 11'(hp);
        vpix     = 11'(vp);
        if (!rst) begin
            foreach (sb_q[i]) sb_q[i] = '0;
            sb_q.push_back(14'h0);
            prev_vs   = 1'b0;
            blink_cnt = 0;
            phase_vis = 1'b1;
        end else begin
            if (BLINK_EN && prev_vs && !vs) begin
                if (blink_cnt == int'(BF) - 1) begin
                    blink_cnt = 0;
                    phase_vis = !phase_vis;
                end else begin
                    blink_cnt++;
                end
            end
            prev_vs = vs;
            sb_q.push_back(model_pix(hs, vs, hd, vd, 11'(hp), 11'(vp)));
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0);
    endtask

    // Output monitor: the entry queued three cycles ago is due now.
    always @(posedge clk) begin
        #1;
        if (sb_q.size() == 3) begin
            m_exp = sb_q.pop_front();
            m_got = {hsync_out, vsync_out, red, green, blue};
            checks++;
            if (m_got !== m_exp) begin
                failures++;
                $display("FAIL pipe_out t=%0t got=%h exp=%h", $time, m_got, m_exp);
            end
        end
    end

    task automatic test_reset();
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'(i % 2), 1'(~i % 2), 1'b1, 1'b1, 17, 35);
            #1;
            checks++;
            if (text_addr !== 14'd0) begin
                failures++;
                $display("FAIL reset_text_addr got=%0d exp=0", text_addr);
            end
            if (i > 0) begin
                checks++;
                if (font_addr !== 12'h000 || {hsync_out, vsync_out, red, green, blue} !== 14'h0) begin
                    failures++;
                    $display("FAIL reset_outputs font_addr=%h out=%h exp=0", font_addr,
                             {hsync_out, vsync_out, red, green, blue});
                end
            end
        end
        for (int i = 0; i < 10; i++)
            step(1'b1, 1'(i % 3 == 0), 1'(i % 4 < 2), 1'b0, 1'b0, 0, 0);
        idle(3);
    endtask

    task automatic test_addr();
        tmem[322]   = 16'h0041;
        fmem[12'h413] = 8'h80;
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 17, 35);
        #1;
        checks++;
        if (text_addr !== 14'd322) begin
            failures++;
            $display("FAIL text_addr got=%0d exp=322", text_addr);
        end
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 18, 35);
        #1;
        checks++;
        if (font_addr !== 12'h413) begin
            failures++;
            $display("FAIL font_addr got=%h exp=413", font_addr);
        end
        idle(3);
    endtask

    task automatic test_pixel_colour();
        tmem[1]       = 16'h0541;
        fmem[12'h410] = 8'h80;
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8, 0);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 9, 0);
        idle(2);
        got = {hsync_out, vsync_out, red, green, blue};
        checks++;
        if (got !== 14'h3F0F) begin
            failures++;
            $display("FAIL fg_magenta got=%h exp=3f0f", got);
        end
        idle(1);
        got = {hsync_out, vsync_out, red, green, blue};
        checks++;
        if (got !== 14'h3000) begin
            failures++;
            $display("FAIL bg_black got=%h exp=3000", got);
        end
        idle(3);
    endtask

    task automatic test_inactive();
        tmem[0]       = 16'h07FF;
        fmem[12'hFF0] = 8'hFF;
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8, 0);
        #1;
        checks++;
        if (text_addr !== 14'd0) begin
            failures++;
            $display("FAIL inactive_addr got=%0d exp=0", text_addr);
        end
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 0, 0);
        idle(2);
        got = {hsync_out, vsync_out, red, green, blue};
        checks++;
        if (got !== 14'h3000) begin
            failures++;
            $display("FAIL hdisp_low_rgb got=%h exp=3000", got);
        end
        idle(3);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 0, 0);
        idle(3);
        got = {hsync_out, vsync_out, red, green, blue};
        checks++;
        if (got !== 14'h3FFF) begin
            failures++;
            $display("FAIL active_white got=%h exp=3fff", got);
        end
        idle(3);
    endtask

    task automatic test_cursor();
        bit inv;
        tmem[322]     = 16'h0541;
        fmem[12'h413] = 8'h80;
        cursor_col    = 8'd2;
        cursor_row    = 6'd2;
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0);
        cursor_on = 1'b1;
        idle(4);
        for (int round = 0; round < 3; round++) begin
            inv = (round != 1) || !BLINK_EN;
            step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 16, 35);
            step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 17, 35);
            idle(2);
            got = {hsync_out, vsync_out, red, green, blue};
            checks++;
            if (got !== (inv ? 14'h3000 : 14'h3F0F)) begin
                failures++;
                $display("FAIL cursor_set_bit round=%0d got=%h exp=%h", round, got,
                         inv ? 14'h3000 : 14'h3F0F);
            end
            idle(1);
            got = {hsync_out, vsync_out, red, green, blue};
            checks++;
            if (got !== (inv ? 14'h3F0F : 14'h3000)) begin
                failures++;
                $display("FAIL cursor_clear_bit round=%0d got=%h exp=%h", round, got,
                         inv ? 14'h3F0F : 14'h3000);
            end
            idle(3);
            for (int p = 0; p < 2; p++) begin
                step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
                idle(3);
            end
            idle(2);
        end
        cursor_on = 1'b0;
        idle(4);
    endtask

    task automatic test_boundary();
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1279, 1023);
        #1;
        checks++;
        if (text_addr !== 14'd10239) begin
            failures++;
            $display("FAIL last_cell_addr got=%0d exp=10239", text_addr);
        end
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 0, 1023);
        #1;
        checks++;
        if (text_addr !== 14'd10080) begin
            failures++;
            $display("FAIL first_col_last_row got=%0d exp=10080", text_addr);
        end
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1279, 0);
        #1;
        checks++;
        if (text_addr !== 14'd159) begin
            failures++;
            $display("FAIL last_col_first_row got=%0d exp=159", text_addr);
        end
        idle(3);
    endtask

    task automatic test_back_to_back();
        cursor_col = 8'd5;
        cursor_row = 6'd10;
        cursor_on  = 1'b1;
        idle(4);
        for (int h = 0; h < 64; h++) step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, h, 165);
        for (int h = 1272; h < 1280; h++) step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, h, 165);
        for (int i = 0; i < 6; i++) step(1'b1, 1'(i < 3 ? 0 : 1), 1'b1, 1'b0, 1'b1, 0, 165);
        for (int h = 0; h < 16; h++) step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, h, 166);
        for (int h = 1264; h < 1280; h++) step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, h, 1023);
        idle(4);
        cursor_on = 1'b0;
        idle(4);
    endtask

    task automatic test_reset_midline();
        tmem[1]       = 16'h0541;
        fmem[12'h410] = 8'hFF;
        for (int h = 8; h < 11; h++) step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, h, 0);
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 11, 0);
        for (int h = 12; h < 16; h++) begin
            step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, h, 0);
            got = {hsync_out, vsync_out, red, green, blue};
            checks++;
            if (got !== (h == 15 ? 14'h3F0F : 14'h0000)) begin
                failures++;
                $display("FAIL midline_reset hpix=%0d got=%h exp=%h", h, got,
                         h == 15 ? 14'h3F0F : 14'h0000);
            end
        end
        idle(4);
    endtask

    initial begin
        for (int i = 0; i < 16384; i++) tmem[i] = 16'($urandom);
        for (int i = 0; i < 4096; i++) fmem[i] = 8'($urandom);
        test_reset();
        test_addr();
        test_pixel_colour();
        test_inactive();
        test_cursor();
        test_boundary();
        test_back_to_back();
        test_reset_midline();
        idle(3);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
